commit_unit: RTL and testbench
==============================

# commit_unit

In-order retire stage sitting directly downstream of the reorder queue. It inspects the queue head each cycle and pops completed entries, one per cycle. Each popped entry produces a registered register-file write. An entry flagged with an exception triggers a queue flush and a recovery sequence.

## Interface
Parameters:
- VAL_WIDTH, 16, result value width
- REG_WIDTH, 4, destination register index width
- ADDR_WIDTH, 4, queue index width; must match the queue
- FLUSH_CYCLES, 2, cycles q_flush_OUT is held (>=1)

Entry layout, ENTRY_W = VAL_WIDTH+REG_WIDTH+3, LSB first: [0] done, [1] exc, [2] wb (writes a register), [REG_WIDTH+2:3] dest, [ENTRY_W-1:REG_WIDTH+3] value.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low
- commit_en_IN  in  1  retire permitted this cycle
- q_empty_IN  in  1  queue empty flag
- q_data_IN  in  ENTRY_W  queue head entry (combinational)
- q_head_IN  in  ADDR_WIDTH  queue head index
- q_pop_OUT  out  1  pop request (combinational)
- q_flush_OUT  out  1  queue flush (registered)
- rf_we_OUT  out  1  register write enable (registered)
- rf_waddr_OUT  out  REG_WIDTH  write address (registered)
- rf_wdata_OUT  out  VAL_WIDTH  write data (registered)
- exc_OUT  out  1  one-cycle exception pulse (registered)
- exc_tag_OUT  out  ADDR_WIDTH  queue index of the faulting entry, held until the next exception
- busy_OUT  out  1  high in any state other than RUN
- retired_OUT  out  16  retired-entry count (see Configuration)
- stalled_OUT  out  16  stall-cycle count (see Configuration)

## Operation
- States: RUN, FLUSH, SETTLE. Reset state is RUN.
- Reset values: all outputs 0; flush counter 0.

RUN:
- head_ok = !q_empty_IN && done && commit_en_IN.
- head_ok && !exc: q_pop_OUT=1. Next edge: rf_we_OUT=wb, rf_waddr_OUT=dest, rf_wdata_OUT=value.
- head_ok && exc: q_pop_OUT=0 and no register write. Next edge: exc_OUT=1, exc_tag_OUT=q_head_IN, q_flush_OUT=1, counter=FLUSH_CYCLES-1, state goes to FLUSH.
- Otherwise: q_pop_OUT=0 and rf_we_OUT=0 next cycle.

FLUSH:
- q_flush_OUT stays high. Counter decrements each cycle.
- When counter is 0: q_flush_OUT drops at the next edge and state goes to SETTLE.
- No pops are issued.

SETTLE:
- Exactly one cycle with no pops, then back to RUN.

General rules:
- q_pop_OUT is forced 0 whenever state != RUN.
- q_pop_OUT is also 0 while reset is low, regardless of inputs.
- exc_OUT and rf_we_OUT are never both high in the same cycle.

## Timing
- Pop latency: q_pop_OUT is combinational in the same cycle the head is seen. The queue advances its head at that edge, so the next entry is visible the following cycle. Sustained throughput is 1 entry/cycle.
- Register-write latency: 1 cycle after the pop cycle.
- Exception to flush: flush is high from edge N+1 through N+FLUSH_CYCLES, where N is the edge ending the detect cycle. Earliest next pop is cycle N+FLUSH_CYCLES+2.
- commit_en_IN low: blocks pops in RUN only. It does not pause FLUSH or SETTLE.
- q_empty_IN high with a stale done bit in q_data_IN: no pop.
- Reset low mid-FLUSH: returns to RUN next edge with all outputs 0. Any pending register write is dropped.
- Counter widths: exact 16-bit, wrap from 0xFFFF to 0.

## Configuration
- COMMIT_STATS_EN defined:
  - retired_OUT increments on every cycle with q_pop_OUT=1.
  - stalled_OUT increments on every RUN cycle with q_empty_IN=0 and q_pop_OUT=0, excluding exception-detect cycles.
  - Both counters clear on reset only, not on flush.
- Undefined: both outputs are tied to 0 and no counter registers are built.

## Test plan
- Reset then 3 done entries (dest 1/2/3, value 0x11/0x22/0x33, wb=1) with commit_en high: pops on 3 consecutive cycles; rf writes (1,0x11), (2,0x22), (3,0x33) one cycle later each; retired_OUT=3.
- Head not done for 4 cycles, then done: no pop for 4 cycles, then a pop; stalled_OUT=4.
- Exception entry at head index 5, FLUSH_CYCLES=2: no pop; exc_OUT pulses 1 cycle; exc_tag_OUT=5; q_flush_OUT high exactly 2 cycles; busy_OUT high for 3 cycles (2 FLUSH + 1 SETTLE); next pop no earlier than the 4th cycle after detect.
- wb=0 done entry: pop occurs and rf_we_OUT stays 0.
- Reset asserted in the second FLUSH cycle: next cycle q_flush_OUT=0, state RUN, counters 0.
- commit_en_IN toggled 1,0,1 with a full queue of done entries: pops 1,0,1; rf_we_OUT follows one cycle later.

Source files
------------

// File: rtl/commit_unit.sv
// In-order retire stage: pops completed entries from the reorder-queue head and issues registered register-file writes.
// Optional retire/stall statistics counters are built when COMMIT_STATS_EN is defined.
module commit_unit #(
   parameter int VAL_WIDTH    = 16,
   parameter int REG_WIDTH    = 4,
   parameter int ADDR_WIDTH   = 4,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic                                   commit_en_IN,
   input  logic                                   q_empty_IN,
   input  logic [VAL_WIDTH+REG_WIDTH+3-1:0]       q_data_IN,
   input  logic [ADDR_WIDTH-1:0]                  q_head_IN,
   output logic                                   q_pop_OUT,
   output logic                                   q_flush_OUT,
   output logic                                   rf_we_OUT,
   output logic [REG_WIDTH-1:0]                   rf_waddr_OUT,
   output logic [VAL_WIDTH-1:0]                   rf_wdata_OUT,
   output logic                                   exc_OUT,
   output logic [ADDR_WIDTH-1:0]                  exc_tag_OUT,
   output logic                                   busy_OUT,
   output logic [15:0]                            retired_OUT,
   output logic [15:0]                            stalled_OUT
);

   localparam int ENTRY_W = VAL_WIDTH + REG_WIDTH + 3;
   localparam int CNT_W   = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_FLUSH  = 2'd1,
      ST_SETTLE = 2'd2
   } state_t;

   state_t                r_state;
   logic [CNT_W-1:0]      r_cnt;
   logic                  r_flush;
   logic                  r_rf_we;
   logic [REG_WIDTH-1:0]  r_rf_waddr;
   logic [VAL_WIDTH-1:0]  r_rf_wdata;
   logic                  r_exc;
   logic [ADDR_WIDTH-1:0] r_exc_tag;

   logic                  w_done;
   logic                  w_exc;
   logic                  w_wb;
   logic [REG_WIDTH-1:0]  w_dest;
   logic [VAL_WIDTH-1:0]  w_value;
   logic                  w_head_ok;
   logic                  w_exc_detect;
   logic                  w_pop;

   assign w_done  = q_data_IN[0];
   assign w_exc   = q_data_IN[1];
   assign w_wb    = q_data_IN[2];
   assign w_dest  = q_data_IN[REG_WIDTH+2:3];
   assign w_value = q_data_IN[ENTRY_W-1:REG_WIDTH+3];

   // A stale done bit behind an empty flag must never be retired.
   assign w_head_ok    = !q_empty_IN && w_done && commit_en_IN;
   assign w_exc_detect = (r_state == ST_RUN) && w_head_ok && w_exc;
   assign w_pop        = reset && (r_state == ST_RUN) && w_head_ok && !w_exc;

   assign q_pop_OUT    = w_pop;
   assign q_flush_OUT  = r_flush;
   assign rf_we_OUT    = r_rf_we;
   assign rf_waddr_OUT = r_rf_waddr;
   assign rf_wdata_OUT = r_rf_wdata;
   assign exc_OUT      = r_exc;
   assign exc_tag_OUT  = r_exc_tag;
   assign busy_OUT     = (r_state != ST_RUN);

   // Retire FSM with registered write-back, exception pulse and flush outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state    <= ST_RUN;
         r_cnt      <= {CNT_W{1'b0}};
         r_flush    <= 1'b0;
         r_rf_we    <= 1'b0;
         r_rf_waddr <= {REG_WIDTH{1'b0}};
         r_rf_wdata <= {VAL_WIDTH{1'b0}};
         r_exc      <= 1'b0;
         r_exc_tag  <= {ADDR_WIDTH{1'b0}};
      end else begin
         case (r_state)
            ST_RUN: begin
               if (w_exc_detect) begin
                  r_rf_we   <= 1'b0;
                  r_exc     <= 1'b1;
                  r_exc_tag <= q_head_IN;
                  r_flush   <= 1'b1;
                  r_cnt     <= CNT_W'(FLUSH_CYCLES - 1);
                  r_state   <= ST_FLUSH;
               end else begin
                  r_exc   <= 1'b0;
                  r_rf_we <= w_pop && w_wb;
                  if (w_pop) begin
                     r_rf_waddr <= w_dest;
                     r_rf_wdata <= w_value;
                  end else begin
                     r_rf_waddr <= r_rf_waddr;
                     r_rf_wdata <= r_rf_wdata;
                  end
               end
            end
            ST_FLUSH: begin
               r_rf_we <= 1'b0;
               r_exc   <= 1'b0;
               if (r_cnt == {CNT_W{1'b0}}) begin
                  r_flush <= 1'b0;
                  r_state <= ST_SETTLE;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            ST_SETTLE: begin
               r_rf_we <= 1'b0;
               r_exc   <= 1'b0;
               r_state <= ST_RUN;
            end
            default: begin
               r_rf_we <= 1'b0;
               r_exc   <= 1'b0;
               r_flush <= 1'b0;
               r_state <= ST_RUN;
            end
         endcase
      end
   end

`ifdef COMMIT_STATS_EN
   logic [15:0] r_retired;
   logic [15:0] r_stalled;

   // Retire and stall statistics; cleared by reset only, free-running through flushes.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_retired <= 16'd0;
         r_stalled <= 16'd0;
      end else begin
         if (w_pop) begin
            r_retired <= r_retired + 16'd1;
         end else begin
            r_retired <= r_retired;
         end
         if ((r_state == ST_RUN) && !q_empty_IN && !w_pop && !w_exc_detect) begin
            r_stalled <= r_stalled + 16'd1;
         end else begin
            r_stalled <= r_stalled;
         end
      end
   end

   assign retired_OUT = r_retired;
   assign stalled_OUT = r_stalled;
`else
   assign retired_OUT = 16'd0;
   assign stalled_OUT = 16'd0;
`endif

endmodule

// File: tb/tb_commit_unit.sv
// Randomised self-checking bench for commit_unit: the bench plays the reorder queue and
// compares every output each cycle against a timer-based reference model.
module tb_commit_unit;
   localparam int VW = 16;
   localparam int RW = 4;
   localparam int AW = 4;
   localparam int FC = 2;
   localparam int EW = VW + RW + 3;
`ifdef COMMIT_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   typedef struct {
      logic          done;
      logic          exc;
      logic          wb;
      logic [RW-1:0] dest;
      logic [VW-1:0] val;
   } ent_t;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          commit_en_IN = 1'b0;
   logic          q_empty_IN = 1'b1;
   logic [EW-1:0] q_data_IN = '0;
   logic [AW-1:0] q_head_IN = '0;
   logic          q_pop_OUT, q_flush_OUT, rf_we_OUT, exc_OUT, busy_OUT;
   logic [RW-1:0] rf_waddr_OUT;
   logic [VW-1:0] rf_wdata_OUT;
   logic [AW-1:0] exc_tag_OUT;
   logic [15:0]   retired_OUT, stalled_OUT;

   always #5 clk = ~clk;

   commit_unit #(.VAL_WIDTH(VW), .REG_WIDTH(RW), .ADDR_WIDTH(AW), .FLUSH_CYCLES(FC)) dut (
      .clk(clk), .reset(reset), .commit_en_IN(commit_en_IN), .q_empty_IN(q_empty_IN),
      .q_data_IN(q_data_IN), .q_head_IN(q_head_IN), .q_pop_OUT(q_pop_OUT),
      .q_flush_OUT(q_flush_OUT), .rf_we_OUT(rf_we_OUT), .rf_waddr_OUT(rf_waddr_OUT),
      .rf_wdata_OUT(rf_wdata_OUT), .exc_OUT(exc_OUT), .exc_tag_OUT(exc_tag_OUT),
      .busy_OUT(busy_OUT), .retired_OUT(retired_OUT), .stalled_OUT(stalled_OUT)
   );

   ent_t          q[$];
   logic [AW-1:0] head_idx = '0;
   logic [EW-1:0] stale = '0;
   int            n_chk = 0;
   int            n_err = 0;
   int            n_pop_obs = 0;

   // reference model: remaining non-RUN cycles and remaining flush cycles
   int            busy_left = 0;
   int            flush_left = 0;
   logic          e_we = 1'b0, e_exc = 1'b0, e_flush = 1'b0;
   logic [RW-1:0] e_waddr = '0;
   logic [VW-1:0] e_wdata = '0;
   logic [AW-1:0] e_tag = '0;
   logic [15:0]   e_ret = 16'd0, e_stl = 16'd0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [EW-1:0] pack(input ent_t e);
      return {e.val, e.dest, e.wb, e.exc, e.done};
   endfunction

   function automatic ent_t mk(input logic done, input logic exc, input logic wb,
                               input logic [RW-1:0] dest, input logic [VW-1:0] val);
      ent_t e;
      e.done = done; e.exc = exc; e.wb = wb; e.dest = dest; e.val = val;
      return e;
   endfunction

   task automatic step(input logic rst, input logic en);
      ent_t h;
      logic hok, hexc, pop, was_flush;
      @(negedge clk);
      h = mk(1'b0, 1'b0, 1'b0, '0, '0);
      if (q.size() != 0) h = q[0];
      reset        = rst;
      commit_en_IN = en;
      q_empty_IN   = (q.size() == 0);
      q_head_IN    = head_idx;
      q_data_IN    = (q.size() != 0) ? pack(h) : stale;
      #1;
      hok  = rst && (busy_left == 0) && (q.size() != 0) && h.done && en;
      hexc = hok && h.exc;
      pop  = hok && !h.exc;
      if (q_pop_OUT) n_pop_obs++;
      chk("pop", q_pop_OUT, pop);
      chk("flush", q_flush_OUT, e_flush);
      chk("rf_we", rf_we_OUT, e_we);
      chk("exc", exc_OUT, e_exc);
      chk("exc_tag", exc_tag_OUT, e_tag);
      chk("busy", busy_OUT, busy_left > 0);
      chk("retired", retired_OUT, STATS ? e_ret : 16'd0);
      chk("stalled", stalled_OUT, STATS ? e_stl : 16'd0);
      if (e_we) begin
         chk("rf_waddr", rf_waddr_OUT, e_waddr);
         chk("rf_wdata", rf_wdata_OUT, e_wdata);
      end
      @(posedge clk);
      was_flush = e_flush;
      if (!rst) begin
         e_we = 1'b0; e_exc = 1'b0; e_flush = 1'b0; e_waddr = '0; e_wdata = '0; e_tag = '0;
         busy_left = 0; flush_left = 0; e_ret = 16'd0; e_stl = 16'd0;
      end else begin
         e_we  = 1'b0;
         e_exc = 1'b0;
         if (busy_left == 0) begin
            if (hexc) begin
               e_exc = 1'b1; e_tag = head_idx; flush_left = FC; busy_left = FC + 1;
            end else if (pop) begin
               e_we = h.wb; e_waddr = h.dest; e_wdata = h.val; e_ret = e_ret + 16'd1;
            end else if (q.size() != 0) begin
               e_stl = e_stl + 16'd1;
            end
         end else begin
            busy_left--;
            if (flush_left > 0) flush_left--;
         end
         e_flush = (flush_left > 0);
      end
      if (pop) begin
         void'(q.pop_front());
         head_idx = head_idx + 1'b1;
      end
      if (was_flush) q.delete();
   endtask

   initial begin
      // reset
      repeat (3) step(1'b0, 1'b1);

      // three back-to-back retires
      q.push_back(mk(1'b1, 1'b0, 1'b1, 4'd1, 16'h0011));
      q.push_back(mk(1'b1, 1'b0, 1'b1, 4'd2, 16'h0022));
      q.push_back(mk(1'b1, 1'b0, 1'b1, 4'd3, 16'h0033));
      n_pop_obs = 0;
      repeat (3) step(1'b1, 1'b1);
      #2;
      chk("dir3_pops", n_pop_obs, 3);
      chk("dir3_waddr", rf_waddr_OUT, 4'd3);
      chk("dir3_wdata", rf_wdata_OUT, 16'h0033);
      step(1'b1, 1'b1);
      #2;
      chk("dir3_retired", retired_OUT, STATS ? 16'd3 : 16'd0);

      // head not done for four cycles
      q.push_back(mk(1'b0, 1'b0, 1'b1, 4'd4, 16'h0044));
      repeat (4) step(1'b1, 1'b1);
      q[0].done = 1'b1;
      step(1'b1, 1'b1);
      #2;
      chk("stall4", stalled_OUT, STATS ? 16'd4 : 16'd0);

      // exception at head index 5
      head_idx = 4'd5;
      q.push_back(mk(1'b1, 1'b1, 1'b1, 4'd7, 16'hdead));
      step(1'b1, 1'b1);
      #2;
      chk("exc_pulse", exc_OUT, 1'b1);
      chk("exc_tag5", exc_tag_OUT, 4'd5);
      repeat (2) step(1'b1, 1'b1);
      q.push_back(mk(1'b1, 1'b0, 1'b1, 4'd8, 16'h0088));
      n_pop_obs = 0;
      step(1'b1, 1'b1);
      chk("settle_nopop", n_pop_obs, 0);
      step(1'b1, 1'b1);
      chk("post_exc_pop", n_pop_obs, 1);

      // wb=0 retire
      q.push_back(mk(1'b1, 1'b0, 1'b0, 4'd9, 16'h0099));
      step(1'b1, 1'b1);
      #2;
      chk("wb0_we", rf_we_OUT, 1'b0);

      // reset during the second flush cycle
      q.push_back(mk(1'b1, 1'b1, 1'b1, 4'd1, 16'h0001));
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      q.delete();
      step(1'b0, 1'b1);
      #2;
      chk("rst_flush", q_flush_OUT, 1'b0);
      chk("rst_busy", busy_OUT, 1'b0);
      chk("rst_retired", retired_OUT, 16'd0);
      step(1'b1, 1'b1);

      // commit enable toggled against a full queue
      for (int i = 0; i < 3; i++) q.push_back(mk(1'b1, 1'b0, 1'b1, 4'(i + 10), 16'(i + 16'h100)));
      step(1'b1, 1'b1);
      step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      q.delete();
      step(1'b1, 1'b1);

      // randomised traffic
      for (int c = 0; c < 3000; c++) begin
         if (q.size() < 8 && $urandom_range(0, 2) == 0)
            q.push_back(mk(1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), 1'($urandom),
                           RW'($urandom), VW'($urandom)));
         if (q.size() != 0 && $urandom_range(0, 1) == 0) q[0].done = 1'b1;
         stale = EW'($urandom);
         step(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
